// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared state encoding, default parameters and clog2 helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_DW        = 8;
   localparam int DEF_MAX_BURST = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Rotating priority picker: first set request at or after start_i.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import rr_arb_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IW    = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    start_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    idx_o,
   output logic             any_o
);

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(start_i) + k) % N_REQ;
         if (!any_o && req_i[j]) begin
            any_o = 1'b1;
            idx_o = IW'(j);
         end
      end
      gnt_o[idx_o] = any_o;
   end

endmodule

`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
// ============================================================================
// Module   : rr_burst_arbiter
// Brief    : Burst-bounded round-robin arbiter feeding a shared 2-stage pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_burst_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int N_REQ     = DEF_N_REQ,
   parameter  int DW        = DEF_DW,
   parameter  int MAX_BURST = DEF_MAX_BURST,
   localparam int IW        = clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] data_in,
   output logic [N_REQ-1:0]    gnt,
   output logic                out_valid,
   output logic [DW-1:0]       out_data,
   output logic [IW-1:0]       out_src
);

   localparam int CW = clog2(MAX_BURST + 1);

   state_t           state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    owner_q;
   logic [CW-1:0]    burst_cnt_q;
   logic [N_REQ-1:0] gnt_q;
   logic             a_valid_q;
   logic [DW-1:0]    a_data_q;
   logic [IW-1:0]    a_src_q;
   logic             b_valid_q;
   logic [DW-1:0]    b_data_q;
   logic [IW-1:0]    b_src_q;

   logic [IW-1:0]    w_owner_next;
   logic [IW-1:0]    w_pick_start;
   logic [N_REQ-1:0] w_pick_gnt;
   logic [IW-1:0]    w_pick_idx;
   logic             w_pick_any;
   logic             w_busy;
   logic             w_accept;
   logic             w_last_beat;
   logic             w_release;

   assign w_busy       = (state_q == ST_BUSY);
   assign w_owner_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign w_accept     = w_busy && req[owner_q];
   assign w_last_beat  = (burst_cnt_q == CW'(MAX_BURST - 1));
   assign w_release    = w_busy && (!req[owner_q] || w_last_beat);

   // While busy the picker is only consulted on release, so it already
   // scans from the post-release pointer to allow a same-edge handover.
   assign w_pick_start = w_busy ? w_owner_next : ptr_q;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req_i   (req),
      .start_i (w_pick_start),
      .gnt_o   (w_pick_gnt),
      .idx_o   (w_pick_idx),
      .any_o   (w_pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         gnt_q       <= '0;
         a_valid_q   <= 1'b0;
         a_data_q    <= '0;
         a_src_q     <= '0;
         b_valid_q   <= 1'b0;
         b_data_q    <= '0;
         b_src_q     <= '0;
      end else begin
         a_valid_q <= w_accept;
         if (w_accept) begin
            a_data_q <= data_in[owner_q*DW +: DW];
            a_src_q  <= owner_q;
         end
         b_valid_q <= a_valid_q;
         b_data_q  <= a_data_q;
         b_src_q   <= a_src_q;

         case (state_q)
            ST_IDLE: begin
               if (w_pick_any) begin
                  gnt_q       <= w_pick_gnt;
                  owner_q     <= w_pick_idx;
                  burst_cnt_q <= '0;
                  state_q     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  ptr_q <= w_owner_next;
                  if (w_pick_any) begin
                     gnt_q       <= w_pick_gnt;
                     owner_q     <= w_pick_idx;
                     burst_cnt_q <= '0;
                  end else begin
                     gnt_q   <= '0;
                     state_q <= ST_IDLE;
                  end
               end else if (w_accept) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               end
            end
            default: begin
               gnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign out_valid = b_valid_q;
   assign out_data  = b_data_q;
   assign out_src   = b_src_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
// ============================================================================
// Module   : tb_rr_burst_arbiter
// Brief    : Directed scoreboard bench for rr_burst_arbiter (N=4, DW=8, MB=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_burst_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int IW = 2;

   typedef struct {
      logic          v;
      logic [IW-1:0] src;
      logic [DW-1:0] data;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    gnt;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_src;

   beat_t         sb[$];
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;
   logic [DW-1:0] dbase[N];

   always #5 clk = ~clk;

   rr_burst_arbiter #(
      .N_REQ     (N),
      .DW        (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Output side of the scoreboard: one entry per clock, popped mid-cycle.
   always @(negedge clk) begin
      beat_t e;
      if (mon_en) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=%0d required=>0", sb.size());
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (out_valid === e.v) else begin
               errors++;
               $error("FAIL out_valid observed=%0b required=%0b", out_valid, e.v);
            end
            if (e.v) begin
               checks++;
               assert (out_data === e.data) else begin
                  errors++;
                  $error("FAIL out_data observed=%0h required=%0h", out_data, e.data);
               end
               checks++;
               assert (out_src === e.src) else begin
                  errors++;
                  $error("FAIL out_src observed=%0d required=%0d", out_src, e.src);
               end
            end
         end
      end
   end

   // One clock: check current grant, drive req/data, predict the next edge.
   task automatic step(input logic [N-1:0] exp_gnt, input logic [N-1:0] r);
      beat_t e;
      int    s;
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      req = r;
      for (int i = 0; i < N; i++) begin
         data_in[i*DW +: DW] = dbase[i];
         dbase[i] = dbase[i] + 1'b1;
      end
      s = 0;
      for (int i = 0; i < N; i++) begin
         if (exp_gnt[i]) s = i;
      end
      e.v    = |(exp_gnt & r);
      e.src  = IW'(s);
      e.data = data_in[s*DW +: DW];
      sb.push_back(e);
   endtask

   task automatic do_reset(input logic [N-1:0] r);
      beat_t e;
      @(negedge clk);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      req    = r;
      #1;
      chk("rst_async_gnt", 32'(gnt), 32'h0);
      chk("rst_async_valid", 32'(out_valid), 32'h0);
      chk("rst_async_data", 32'(out_data), 32'h0);
      chk("rst_async_src", 32'(out_src), 32'h0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_hold_gnt", 32'(gnt), 32'h0);
      chk("rst_hold_valid", 32'(out_valid), 32'h0);
      rst_n  = 1'b1;
      e.v    = 1'b0;
      e.src  = '0;
      e.data = '0;
      sb.push_back(e);
      sb.push_back(e);
      mon_en = 1'b1;
   endtask

   initial begin
      int          seq[5];
      logic [N-1:0] g;
      seq     = '{0, 1, 2, 3, 0};
      rst_n   = 1'b0;
      req     = '0;
      data_in = '0;
      for (int i = 0; i < N; i++) dbase[i] = DW'(i * 8'h40);

      // Reset with every requester asserted.
      do_reset(4'b1111);
      repeat (2) step(4'b0000, 4'b0000);

      // Single requester: continuous stream, re-grant after each burst.
      do_reset(4'b0000);
      dbase[2] = 8'h9F;
      step(4'b0000, 4'b0100);
      repeat (12) step(4'b0100, 4'b0100);
      step(4'b0100, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);

      // Full contention: 0,1,2,3,0 each for exactly MB beats.
      do_reset(4'b0000);
      step(4'b0000, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         g = 4'(1 << seq[k]);
         repeat (MB) step(g, 4'b1111);
      end
      step(4'b0010, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);

      // Early release: owner 0 drops after 2 beats, requester 3 takes over.
      do_reset(4'b0000);
      step(4'b0000, 4'b1001);
      repeat (2) step(4'b0001, 4'b1001);
      step(4'b0001, 4'b1000);
      repeat (MB) step(4'b1000, 4'b1000);
      step(4'b1000, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);

      // Mid-burst reset during requester 1's third beat.
      do_reset(4'b0000);
      step(4'b0000, 4'b0110);
      repeat (2) step(4'b0010, 4'b0110);
      do_reset(4'b0110);
      step(4'b0000, 4'b0110);
      repeat (MB) step(4'b0010, 4'b0110);
      step(4'b0100, 4'b0110);
      step(4'b0100, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);

      // Drain to idle from requester 3, then pointer wrap favours 0.
      do_reset(4'b0000);
      step(4'b0000, 4'b1000);
      repeat (MB) step(4'b1000, 4'b1000);
      step(4'b1000, 4'b0000);
      repeat (2) step(4'b0000, 4'b0000);
      step(4'b0000, 4'b1001);
      step(4'b0001, 4'b1001);
      step(4'b0001, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);

      @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin scheduler sharing one two-stage register datapath among N requesters.
- Stage A captures the granted requester's word. Stage B follows stage A (b <= a), so every accepted beat emerges exactly 2 cycles later.
- The arbiter bounds each ownership to MAX_BURST beats so no requester starves the shared pipeline.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DW, 8: data width per requester.
- MAX_BURST, 4: maximum consecutive beats per grant (1..15).

Ports:
- clk, input, 1: single clock; all state on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, N_REQ: per-requester request; also acts as the beat-valid.
- data_in, input, N_REQ*DW: packed words; requester i uses bits [i*DW +: DW].
- gnt, output, N_REQ: one-hot grant (registered), or all zero.
- out_valid, output, 1: stage B holds a valid beat.
- out_data, output, DW: stage B data.
- out_src, output, clog2(N_REQ): index of the requester that supplied the stage B beat.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, out_valid=0, out_data=0, out_src=0.
  - Stage A cleared, state=IDLE, ptr=0, burst_cnt=0.
  - In-flight beats are dropped.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req!=0, at the posedge pick the first set req scanning ptr, ptr+1, … mod N_REQ.
  - Register gnt one-hot to the winner, owner=winner, burst_cnt=0, go to BUSY.
  - If req==0, stay in IDLE with gnt=0.
- Beat acceptance:
  - A beat is accepted at a posedge iff state=BUSY and req[owner]=1.
  - Stage A takes data_in[owner] and owner with valid=1; otherwise stage A valid=0.
  - Stage B copies stage A every cycle, including valid.
  - Latency from acceptance edge to out_valid=1 is one further edge: the beat is visible 2 cycles after gnt is first seen with req high.
- Burst counting: burst_cnt increments on each accepted beat.
- Release at a posedge in BUSY occurs if either:
  - req[owner]=0 (no beat taken that edge), or
  - a beat is accepted with burst_cnt==MAX_BURST-1.
- On release:
  - ptr=owner+1 mod N_REQ.
  - Re-pick in the same edge from the current req, scanning from the new ptr.
  - If a winner exists: gnt switches directly to it with no bubble, burst_cnt=0, stay in BUSY.
  - Otherwise: gnt=0, go to IDLE.
- Sole requester: if only the owner still requests after burst exhaustion, it is re-granted with a fresh count. gnt stays constant; burst_cnt restarts at 0.
- req changes: changes on non-owner lines during a burst are ignored until release.
- gnt is never multi-hot.
- out_src always matches the source of out_data.
- ptr wrap: N_REQ-1 → 0.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_BUSY=1);
  - default N_REQ/DW/MAX_BURST;
  - the clog2 function.
- One combinational sub-module, rr_pick:
  - inputs: req vector, start pointer;
  - outputs: one-hot winner, winner index, any flag.
  - Instantiated once in rr_burst_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, out_valid=0, out_data=0x00. Assert rst_n=0 mid-cycle → outputs clear without waiting for a clock edge.
- Single requester: req=4'b0100 held, data_in[2] increments 0xA0,0xA1,… per cycle → gnt=4'b0100 one edge later. out_valid=1 two cycles after the first acceptance with out_data=0xA0, out_src=2. After 4 beats gnt stays 4'b0100 with no gap, and the stream continues 0xA4….
- Full contention: req=4'b1111 continuous → grant sequence 0,1,2,3,0, each owner held exactly 4 cycles with no idle cycle. out_src follows the same sequence delayed 2 cycles.
- Early release: req=4'b1001, owner 0; drop req[0] after 2 beats → at the next edge gnt=4'b1000. out_valid shows one 0 cycle (the unaccepted edge), then beats from src 3.
- Mid-burst reset: req=4'b0110, reset asserted during requester 1's 3rd beat and released → first grant goes to requester 1 (ptr=0 scan). Pre-reset beats never appear on out_valid.
- Drain to idle: single burst from requester 3, then req=0 → gnt=0 after release, state IDLE. out_valid stays high for exactly the remaining 2 pipeline beats, then 0. The next request to 0 is granted, because ptr wrapped 3→0.
